byte_pack_arbiter: RTL and testbench

BYTE_PACK_ARBITER -- requirements
Module: byte_pack_arbiter

---
 rtl/byte_pack_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_byte_pack_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/byte_pack_arbiter.sv
// Two-channel byte-to-word packer with a shared, round-robin arbitrated packer.
// Each channel owns a one-byte pending slot, a 4-byte assembly register and an
// idle timer. The arbiter hands the single packer slot to one pending channel
// per cycle. Words are emitted MSB-first: the first byte of a word lands in
// [31:24].

// Per-channel state: pending slot, word assembly, idle timeout and outputs.
module byte_pack_lane #(
    parameter int TIMEOUT = 100000,
    parameter int TW      = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        grant,
    output logic        pend_valid,
    output logic [31:0] ext_data,
    output logic        word_valid,
    output logic        overrun,
    output logic        timeout
);

    // Idle count at which a partial word is abandoned.
    localparam logic [TW-1:0] IDLE_MAX = TW'(TIMEOUT - 1);

    logic [7:0]    pend_data;
    logic [1:0]    byte_cnt;
    logic [31:0]   assembly;
    logic [TW-1:0] idle_cnt;

    // The byte leaving the pending slot this cycle appended to the assembly.
    logic [31:0] next_word;
    assign next_word = {assembly[23:0], pend_data};

    // Pending slot: a strobe fills it if empty or if it is being drained this
    // same cycle; otherwise the incoming byte is dropped and flagged.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_valid <= 1'b0;
            pend_data  <= 8'h00;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (rx_valid) begin
                if (!pend_valid || grant) begin
                    pend_data  <= rx_data;
                    pend_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (grant) begin
                pend_valid <= 1'b0;
            end
        end
    end

    // Word assembly and idle timeout. A grant always beats a timeout in the
    // same cycle, so a byte arriving on the last idle cycle is never lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt   <= 2'd0;
            assembly   <= 32'h0;
            idle_cnt   <= '0;
            ext_data   <= 32'h0;
            word_valid <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            timeout    <= 1'b0;
            if (grant) begin
                assembly <= next_word;
                idle_cnt <= '0;
                if (byte_cnt == 2'd3) begin
                    ext_data   <= next_word;
                    word_valid <= 1'b1;
                    byte_cnt   <= 2'd0;
                end else begin
                    byte_cnt <= byte_cnt + 2'd1;
                end
            end else if (byte_cnt == 2'd0) begin
                idle_cnt <= '0;
            end else if (idle_cnt == IDLE_MAX) begin
                // Stale bytes in assembly need no clearing: four fresh bytes
                // shift them out before the next word is emitted.
                byte_cnt <= 2'd0;
                idle_cnt <= '0;
                timeout  <= 1'b1;
            end else begin
                idle_cnt <= idle_cnt + 1'b1;
            end
        end
    end

endmodule

// Top level: two lanes sharing one packer slot through a round-robin arbiter.
module byte_pack_arbiter #(
    parameter int TIMEOUT = 100000,
    parameter int TW      = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data_1,
    input  logic        rx_valid_1,
    input  logic [7:0]  rx_data_2,
    input  logic        rx_valid_2,
    output logic [31:0] ext_data_1,
    output logic [31:0] ext_data_2,
    output logic        word_valid_1,
    output logic        word_valid_2,
    output logic        overrun_1,
    output logic        overrun_2,
    output logic        timeout_1,
    output logic        timeout_2
);

    localparam int NUM_LANES = 2;

    typedef enum logic {LAST1, LAST2} rr_state_t;

    rr_state_t last_grant;

    logic [NUM_LANES-1:0][7:0]  rx_data;
    logic [NUM_LANES-1:0]       rx_valid;
    logic [NUM_LANES-1:0]       pend_valid;
    logic [NUM_LANES-1:0]       grant;
    logic [NUM_LANES-1:0][31:0] ext_data;
    logic [NUM_LANES-1:0]       word_valid;
    logic [NUM_LANES-1:0]       overrun;
    logic [NUM_LANES-1:0]       timeout;

    assign rx_data  = {rx_data_2, rx_data_1};
    assign rx_valid = {rx_valid_2, rx_valid_1};

    assign ext_data_1   = ext_data[0];
    assign ext_data_2   = ext_data[1];
    assign word_valid_1 = word_valid[0];
    assign word_valid_2 = word_valid[1];
    assign overrun_1    = overrun[0];
    assign overrun_2    = overrun[1];
    assign timeout_1    = timeout[0];
    assign timeout_2    = timeout[1];

    // Grant: a lone pending channel always wins; on a tie the channel that
    // was not served last goes first.
    always_comb begin
        grant    = '0;
        grant[0] = pend_valid[0] & (~pend_valid[1] | (last_grant == LAST2));
        grant[1] = pend_valid[1] & (~pend_valid[0] | (last_grant == LAST1));
    end

    // Round-robin pointer; resets to LAST2 so channel 1 takes the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= LAST2;
        end else begin
            case (last_grant)
                LAST1:   if (grant[1]) last_grant <= LAST2;
                         else if (grant[0]) last_grant <= LAST1;
                LAST2:   if (grant[0]) last_grant <= LAST1;
                         else if (grant[1]) last_grant <= LAST2;
                default: last_grant <= LAST2;
            endcase
        end
    end

    genvar i;
    generate
        for (i = 0; i < NUM_LANES; i++) begin : g_lane
            byte_pack_lane #(
                .TIMEOUT (TIMEOUT),
                .TW      (TW)
            ) u_lane (
                .clk        (clk),
                .rst        (rst),
                .rx_data    (rx_data[i]),
                .rx_valid   (rx_valid[i]),
                .grant      (grant[i]),
                .pend_valid (pend_valid[i]),
                .ext_data   (ext_data[i]),
                .word_valid (word_valid[i]),
                .overrun    (overrun[i]),
                .timeout    (timeout[i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_byte_pack_arbiter.sv
// Testbench for byte_pack_arbiter: directed scenarios plus randomized traffic
// compared cycle by cycle against a byte-list reference model.
module tb_byte_pack_arbiter;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data_1 = 8'h00, rx_data_2 = 8'h00;
    logic        rx_valid_1 = 1'b0, rx_valid_2 = 1'b0;
    logic [31:0] ext_data_1, ext_data_2;
    logic        word_valid_1, word_valid_2, overrun_1, overrun_2, timeout_1, timeout_2;

    int checks = 0;
    int errors = 0;

    byte_pack_arbiter #(.TIMEOUT(TO), .TW(5)) dut (
        .clk(clk), .rst(rst),
        .rx_data_1(rx_data_1), .rx_valid_1(rx_valid_1),
        .rx_data_2(rx_data_2), .rx_valid_2(rx_valid_2),
        .ext_data_1(ext_data_1), .ext_data_2(ext_data_2),
        .word_valid_1(word_valid_1), .word_valid_2(word_valid_2),
        .overrun_1(overrun_1), .overrun_2(overrun_2),
        .timeout_1(timeout_1), .timeout_2(timeout_2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor (cumulative counts, cycle of most recent pulse).
    int wv_n[2], ov_n[2], to_n[2], wv_cyc[2], to_cyc[2];
    initial for (int k = 0; k < 2; k++) begin
        wv_n[k] = 0; ov_n[k] = 0; to_n[k] = 0; wv_cyc[k] = -1; to_cyc[k] = -1;
    end
    always @(negedge clk) begin
        if (word_valid_1) begin wv_n[0]++; wv_cyc[0] = cyc; end
        if (word_valid_2) begin wv_n[1]++; wv_cyc[1] = cyc; end
        if (overrun_1) ov_n[0]++;
        if (overrun_2) ov_n[1]++;
        if (timeout_1) begin to_n[0]++; to_cyc[0] = cyc; end
        if (timeout_2) begin to_n[1]++; to_cyc[1] = cyc; end
    end

    // Reference model: a one-byte mailbox per channel, a list of collected
    // bytes per channel, and a "who was served last" pointer.
    bit         mpv[2];
    logic [7:0] mpd[2];
    logic [7:0] mb[2][4];
    int         mn[2];
    int         midle[2];
    int         mlast;
    logic [31:0] mext[2];
    bit         mwv[2], mov[2], mto[2];
    bit         g[2], v[2];
    logic [7:0] d[2];

    always @(posedge clk) begin
        v[0] = rx_valid_1; v[1] = rx_valid_2;
        d[0] = rx_data_1;  d[1] = rx_data_2;
        if (rst) begin
            for (int c = 0; c < 2; c++) begin
                mpv[c] = 0; mpd[c] = 0; mn[c] = 0; midle[c] = 0;
                mext[c] = 0; mwv[c] = 0; mov[c] = 0; mto[c] = 0;
            end
            mlast = 2;
        end else begin
            g[0] = mpv[0] && (!mpv[1] || mlast == 2);
            g[1] = mpv[1] && (!mpv[0] || mlast == 1);
            for (int c = 0; c < 2; c++) begin
                mwv[c] = 0; mto[c] = 0; mov[c] = 0;
                if (g[c]) begin
                    mb[c][mn[c]] = mpd[c];
                    mn[c]++;
                    midle[c] = 0;
                    if (mn[c] == 4) begin
                        mext[c] = {mb[c][0], mb[c][1], mb[c][2], mb[c][3]};
                        mwv[c] = 1;
                        mn[c] = 0;
                    end
                end else if (mn[c] == 0) begin
                    midle[c] = 0;
                end else if (midle[c] == TO - 1) begin
                    mn[c] = 0; midle[c] = 0; mto[c] = 1;
                end else begin
                    midle[c]++;
                end
                if (v[c]) begin
                    if (!mpv[c] || g[c]) begin mpd[c] = d[c]; mpv[c] = 1; end
                    else mov[c] = 1;
                end else if (g[c]) begin
                    mpv[c] = 0;
                end
            end
            if (g[0]) mlast = 1;
            else if (g[1]) mlast = 2;
        end
    end

    task automatic drive(input bit v1, input logic [7:0] d1, input bit v2, input logic [7:0] d2);
        @(negedge clk);
        rx_valid_1 = v1; rx_data_1 = d1; rx_valid_2 = v2; rx_data_2 = d2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; rx_valid_1 = 0; rx_valid_2 = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        // strobes during reset must be ignored
        rx_valid_1 = 1; rx_data_1 = 8'($urandom); rx_valid_2 = 1; rx_data_2 = 8'($urandom);
        repeat (3) @(negedge clk);
        checks++;
        if ({ext_data_1, ext_data_2, word_valid_1, word_valid_2, overrun_1, overrun_2,
             timeout_1, timeout_2} !== 70'h0) begin
            errors++;
            $display("FAIL reset_outputs got %h/%h flags %b%b%b%b%b%b exp all zero",
                     ext_data_1, ext_data_2, word_valid_1, word_valid_2,
                     overrun_1, overrun_2, timeout_1, timeout_2);
        end
        rst = 1'b0; rx_valid_1 = 0; rx_valid_2 = 0;
        repeat (3) drive(0, 0, 0, 0);
        checks++;
        if (wv_n[0] + wv_n[1] + ov_n[0] + ov_n[1] != 0) begin
            errors++;
            $display("FAIL reset_no_pulses got %0d exp 0", wv_n[0] + wv_n[1] + ov_n[0] + ov_n[1]);
        end
    endtask

    task automatic test_single_word();
        logic [7:0] b[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        int w0 = wv_n[0], c0 = 0;
        for (int i = 0; i < 4; i++) begin
            drive(1, b[i], 0, 0);
            if (i == 3) c0 = cyc;
            repeat (3) drive(0, 0, 0, 0);
        end
        repeat (4) drive(0, 0, 0, 0);
        checks++;
        if (ext_data_1 !== 32'h11223344) begin
            errors++; $display("FAIL single_data got %h exp 11223344", ext_data_1);
        end
        checks++;
        if (wv_n[0] - w0 != 1) begin
            errors++; $display("FAIL single_pulses got %0d exp 1", wv_n[0] - w0);
        end
        checks++;
        if (wv_cyc[0] != c0 + 2) begin
            errors++; $display("FAIL single_latency got %0d exp %0d", wv_cyc[0], c0 + 2);
        end
    endtask

    task automatic test_zero_bytes();
        int w0 = wv_n[0];
        for (int i = 0; i < 4; i++) begin
            drive(1, 8'h00, 0, 0);
            drive(0, 0, 0, 0);
        end
        repeat (4) drive(0, 0, 0, 0);
        checks++;
        if (ext_data_1 !== 32'h0) begin
            errors++; $display("FAIL zero_data got %h exp 00000000", ext_data_1);
        end
        checks++;
        if (wv_n[0] - w0 != 1) begin
            errors++; $display("FAIL zero_pulses got %0d exp 1", wv_n[0] - w0);
        end
    endtask

    task automatic test_both_channels();
        logic [7:0] a[4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        logic [7:0] b[4] = '{8'h01, 8'h02, 8'h03, 8'h04};
        int w1, w2, o1, o2;
        do_reset();
        w1 = wv_n[0]; w2 = wv_n[1]; o1 = ov_n[0]; o2 = ov_n[1];
        for (int i = 0; i < 4; i++) begin
            drive(1, a[i], 1, b[i]);
            drive(0, 0, 0, 0);
        end
        repeat (5) drive(0, 0, 0, 0);
        checks++;
        if (ext_data_1 !== 32'hAABBCCDD) begin
            errors++; $display("FAIL both_data1 got %h exp aabbccdd", ext_data_1);
        end
        checks++;
        if (ext_data_2 !== 32'h01020304) begin
            errors++; $display("FAIL both_data2 got %h exp 01020304", ext_data_2);
        end
        checks++;
        if (wv_n[0] - w1 != 1 || wv_n[1] - w2 != 1) begin
            errors++; $display("FAIL both_pulses got %0d/%0d exp 1/1", wv_n[0] - w1, wv_n[1] - w2);
        end
        checks++;
        if (wv_cyc[1] != wv_cyc[0] + 1) begin
            errors++; $display("FAIL both_order got ch1@%0d ch2@%0d exp ch2 one after ch1", wv_cyc[0], wv_cyc[1]);
        end
        checks++;
        if (ov_n[0] - o1 + ov_n[1] - o2 != 0) begin
            errors++; $display("FAIL both_overrun got %0d exp 0", ov_n[0] - o1 + ov_n[1] - o2);
        end
    endtask

    task automatic test_timeout();
        logic [7:0] b[4] = '{8'h0A, 8'h0B, 8'h0C, 8'h0D};
        int t0, w0, c0 = 0;
        do_reset();
        t0 = to_n[1]; w0 = wv_n[1];
        drive(0, 0, 1, 8'hEE);
        drive(0, 0, 0, 0);
        drive(0, 0, 1, 8'hFF);
        c0 = cyc;
        repeat (30) drive(0, 0, 0, 0);
        checks++;
        if (to_n[1] - t0 != 1) begin
            errors++; $display("FAIL timeout_pulses got %0d exp 1", to_n[1] - t0);
        end
        checks++;
        if (to_cyc[1] != c0 + 2 + TO) begin
            errors++; $display("FAIL timeout_cycle got %0d exp %0d", to_cyc[1], c0 + 2 + TO);
        end
        checks++;
        if (ext_data_2 !== 32'h0 || wv_n[1] != w0) begin
            errors++; $display("FAIL timeout_keep got %h wv %0d exp 00000000 wv 0", ext_data_2, wv_n[1] - w0);
        end
        for (int i = 0; i < 4; i++) drive(0, 0, 1, b[i]);
        repeat (4) drive(0, 0, 0, 0);
        checks++;
        if (ext_data_2 !== 32'h0A0B0C0D) begin
            errors++; $display("FAIL timeout_next got %h exp 0a0b0c0d", ext_data_2);
        end
    endtask

    task automatic test_rst_mid_word();
        logic [7:0] b[4] = '{8'h55, 8'h66, 8'h77, 8'h88};
        int w0, t0;
        do_reset();
        for (int i = 0; i < 3; i++) drive(1, 8'hE0 + 8'(i), 0, 0);
        drive(0, 0, 0, 0);
        w0 = wv_n[0]; t0 = to_n[0];
        @(negedge clk);
        rst = 1'b1; rx_valid_1 = 1; rx_data_1 = 8'h99;
        @(negedge clk);
        rst = 1'b0; rx_valid_1 = 0;
        for (int i = 0; i < 4; i++) drive(1, b[i], 0, 0);
        repeat (4) drive(0, 0, 0, 0);
        checks++;
        if (ext_data_1 !== 32'h55667788) begin
            errors++; $display("FAIL rstmid_data got %h exp 55667788", ext_data_1);
        end
        checks++;
        if (wv_n[0] - w0 != 1 || to_n[0] != t0) begin
            errors++; $display("FAIL rstmid_pulses got wv %0d to %0d exp wv 1 to 0", wv_n[0] - w0, to_n[0] - t0);
        end
    endtask

    task automatic test_overrun();
        int o0;
        logic [5:0] gf, ef;
        do_reset();
        o0 = ov_n[0] + ov_n[1];
        for (int i = 0; i < 8 + 40; i++) begin
            if (i < 8) drive(1, 8'($urandom), 1, 8'($urandom));
            else drive(0, 0, 0, 0);
            gf = {word_valid_1, word_valid_2, overrun_1, overrun_2, timeout_1, timeout_2};
            ef = {mwv[0], mwv[1], mov[0], mov[1], mto[0], mto[1]};
            checks++;
            if (gf !== ef) begin
                errors++; $display("FAIL ovr_flags cyc %0d got %b exp %b", cyc, gf, ef);
            end
            checks++;
            if (ext_data_1 !== mext[0] || ext_data_2 !== mext[1]) begin
                errors++; $display("FAIL ovr_data cyc %0d got %h/%h exp %h/%h", cyc, ext_data_1, ext_data_2, mext[0], mext[1]);
            end
        end
        checks++;
        if (ov_n[0] + ov_n[1] - o0 == 0) begin
            errors++; $display("FAIL ovr_seen got 0 exp >0");
        end
    endtask

    task automatic test_random();
        int pct[4] = '{90, 50, 10, 2};
        logic [5:0] gf, ef;
        do_reset();
        for (int i = 0; i < 2400; i++) begin
            int p = pct[(i / 150) % 4];
            drive($urandom_range(99) < p, 8'($urandom), $urandom_range(99) < p, 8'($urandom));
            gf = {word_valid_1, word_valid_2, overrun_1, overrun_2, timeout_1, timeout_2};
            ef = {mwv[0], mwv[1], mov[0], mov[1], mto[0], mto[1]};
            checks++;
            if (gf !== ef) begin
                errors++; $display("FAIL rnd_flags cyc %0d got %b exp %b", cyc, gf, ef);
            end
            checks++;
            if (ext_data_1 !== mext[0] || ext_data_2 !== mext[1]) begin
                errors++; $display("FAIL rnd_data cyc %0d got %h/%h exp %h/%h", cyc, ext_data_1, ext_data_2, mext[0], mext[1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_zero_bytes();
        test_both_channels();
        test_timeout();
        test_rst_mid_word();
        test_overrun();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
